// File: rtl/adder_sweep_checker.sv
`default_nettype none
// ============================================================================
// Module   : adder_sweep_checker
// Purpose  : Self-test sweeper for an N-bit full-adder tile. Walks every
//            {cin, b, a} combination onto vec_out, holds each vector for
//            SETTLE cycles, then samples dut_res and compares it against an
//            internal golden sum. Exposes error count, first failing vector
//            and a done/pass summary.
// Ports    : clk, rst_n (async, active low), ena (global hold), start (pulse)
//            vec_out  [2N:0]  stimulus {cin, b, a} to the adder
//            dut_res  [N:0]   adder result {cout, sum}
//            busy, done, pass, err_count [2N+1:0],
//            first_fail [2N:0], first_fail_valid
// Revision : 1.0 - initial release
// ============================================================================
module adder_sweep_checker #(
  parameter int N      = 1,
  parameter int SETTLE = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic             start,
  output logic [2*N:0]     vec_out,
  input  logic [N:0]       dut_res,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [2*N+1:0]   err_count,
  output logic [2*N:0]     first_fail,
  output logic             first_fail_valid
);

  localparam int VW  = 2 * N + 1;
  localparam int RW  = N + 1;
  localparam int CW  = 2 * N + 2;
  localparam int SCW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [SCW-1:0] C_RELOAD = SCW'(SETTLE - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DRIVE  = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t           state_q;
  logic [VW-1:0]    vec_q;
  logic [SCW-1:0]   cnt_q;
  logic [CW-1:0]    err_count_q;
  logic [VW-1:0]    first_fail_q;
  logic             first_fail_valid_q;
  logic             busy_q;
  logic             done_q;
  logic             pass_q;

  // Golden result computed one bit wider than the operands so cout is kept.
  logic [N-1:0]     op_a;
  logic [N-1:0]     op_b;
  logic             op_cin;
  logic [RW-1:0]    exp_res;
  logic             mismatch;
  logic [CW-1:0]    err_count_d;

  assign op_a        = vec_q[N-1:0];
  assign op_b        = vec_q[2*N-1:N];
  assign op_cin      = vec_q[2*N];
  assign exp_res     = {1'b0, op_a} + {1'b0, op_b} + {{N{1'b0}}, op_cin};
  assign mismatch    = (dut_res != exp_res);
  assign err_count_d = err_count_q + {{(CW-1){1'b0}}, mismatch};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q            <= IDLE;
      vec_q              <= '0;
      cnt_q              <= '0;
      err_count_q        <= '0;
      first_fail_q       <= '0;
      first_fail_valid_q <= 1'b0;
      busy_q             <= 1'b0;
      done_q             <= 1'b0;
      pass_q             <= 1'b0;
    end else if (ena) begin
      case (state_q)
        IDLE, DONE: begin
          if (start) begin
            state_q            <= DRIVE;
            vec_q              <= '0;
            cnt_q              <= C_RELOAD;
            err_count_q        <= '0;
            first_fail_q       <= '0;
            first_fail_valid_q <= 1'b0;
            busy_q             <= 1'b1;
            done_q             <= 1'b0;
            pass_q             <= 1'b0;
          end
        end
        DRIVE: begin
          // Counter runs SETTLE-1 .. 0, giving exactly SETTLE DRIVE cycles.
          if (cnt_q == '0) begin
            state_q <= SAMPLE;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        SAMPLE: begin
          if (mismatch) begin
            err_count_q <= err_count_d;
            if (!first_fail_valid_q) begin
              first_fail_q       <= vec_q;
              first_fail_valid_q <= 1'b1;
            end
          end
          if (vec_q == '1) begin
            // Final vector: its own mismatch is already folded into err_count_d.
            state_q <= DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            pass_q  <= (err_count_d == '0);
          end else begin
            state_q <= DRIVE;
            vec_q   <= vec_q + 1'b1;
            cnt_q   <= C_RELOAD;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign vec_out          = vec_q;
  assign busy             = busy_q;
  assign done             = done_q;
  assign pass             = pass_q;
  assign err_count        = err_count_q;
  assign first_fail       = first_fail_q;
  assign first_fail_valid = first_fail_valid_q;

endmodule
`default_nettype wire

// File: doc/adder_sweep_checker.md
Name: adder_sweep_checker

Overview:
Self-test stage that sits directly upstream of the full-adder tile and also reads its result back. It sweeps every operand/carry-in combination into the adder, holds each vector for a settle window, samples the adder result and compares it against an internal golden sum. Error count, first failing vector and a pass/done summary are exposed for the top level to drive onto uo_out.

Parameters:
N, 1, adder operand width; the vector is 2N+1 bits wide and the result is N+1 bits wide
SETTLE, 4, number of cycles each vector is held before sampling; must be ≥1

Ports:
clk  input  1  system clock
rst_n  input  1  active-low reset, asynchronous assert
ena  input  1  design enable; when low, all state holds
start  input  1  single-cycle request to begin a sweep
vec_out  output  2N+1  stimulus to the adder: [N-1:0]=a, [2N-1:N]=b, [2N]=cin
dut_res  input  N+1  adder result: [N-1:0]=sum, [N]=cout
busy  output  1  sweep in progress
done  output  1  sweep finished; result fields valid
pass  output  1  done and err_count==0
err_count  output  2N+2  number of mismatching vectors
first_fail  output  2N+1  vector of the first mismatch
first_fail_valid  output  1  at least one mismatch recorded

Behaviour:
- One clock. Reset is asynchronous and active-low (rst_n); clock port is clk.
- Reset values: state=IDLE, vec_out=0, busy=0, done=0, pass=0, err_count=0, first_fail=0, first_fail_valid=0, settle counter=0.
- ena=0: no register changes, including the FSM, counters and outputs. start is ignored while ena=0.
- Golden: exp = a + b + cin, computed at N+1 bits with no truncation.
- FSM states: IDLE, DRIVE, SAMPLE, DONE.
- IDLE/DONE + start=1 → DRIVE:
  - vec_out←0, err_count←0, first_fail←0, first_fail_valid←0.
  - done←0, pass←0, busy←1, settle counter←SETTLE-1.
- DRIVE:
  - Decrement the settle counter each cycle.
  - When the counter is 0, go to SAMPLE.
  - Each vector is held for exactly SETTLE cycles in DRIVE.
- SAMPLE (one cycle), comparing dut_res with exp(vec_out):
  - On mismatch: err_count increments.
  - If first_fail_valid=0: first_fail←vec_out and first_fail_valid←1.
  - If vec_out is all ones: go to DONE, busy←0, done←1, pass←(final err_count==0). The final vector's mismatch is included.
  - Otherwise: vec_out←vec_out+1, counter←SETTLE-1, go to DRIVE.
- Per-vector time is SETTLE+1 cycles. Total time from the start-accept edge to done=1 is 2^(2N+1)·(SETTLE+1) cycles.
- vec_out stays at all ones in DONE. Result fields hold until the next start.
- start while busy (DRIVE/SAMPLE) is ignored; the sweep is not restarted.
- err_count is 2N+2 bits, so it cannot overflow; it reaches at most 2^(2N+1).
- rst_n low mid-sweep aborts immediately to the reset values. A new start is required after reset.
- dut_res is sampled only in SAMPLE; its value in any other state has no effect.

Test Plan:
- Correct adder, N=1, SETTLE=4, start pulse:
  - vec_out steps 0..7, each held 4 cycles then sampled.
  - done=1 exactly 40 cycles after start accept.
  - pass=1, err_count=0, first_fail_valid=0.
- Faulty adder with sum stuck at 0:
  - Mismatches occur at vectors 1,2,4,7.
  - err_count=4, first_fail=3'b001, first_fail_valid=1, pass=0, done=1.
- Fault only on the final vector 7 (cout forced to 0):
  - err_count=1, first_fail=3'b111, pass=0.
  - Confirms the last SAMPLE is counted before DONE.
- start pulsed again at vector 3 mid-sweep:
  - Ignored; sweep continues and done still arrives at cycle 40.
- rst_n asserted at vector 5:
  - All outputs return to their reset values asynchronously.
  - A new start then completes a full 40-cycle sweep.
- ena held low for 10 cycles during DRIVE of vector 2:
  - vec_out and the counters freeze.
  - done arrives at cycle 50.
  - Results are identical to the uninterrupted run.
